// File: rtl/kv_cmd_sequencer_pkg.sv
// Shared constants and types for the KV command sequencer: opcodes, kv_op codes, status bytes, FSM states.
// Latency: none (declarations only). Backpressure: none.
package kv_cmd_sequencer_pkg;

   localparam int PKT_BYTES = 13;
   localparam int KEY_W     = 32;
   localparam int VAL_W     = 64;

   localparam logic [7:0] OP_PUT = 8'h01;
   localparam logic [7:0] OP_GET = 8'h02;
   localparam logic [7:0] OP_DEL = 8'h03;

   localparam logic [1:0] KV_NONE = 2'b00;
   localparam logic [1:0] KV_PUT  = 2'b01;
   localparam logic [1:0] KV_GET  = 2'b10;
   localparam logic [1:0] KV_DEL  = 2'b11;

   localparam logic [7:0] ST_OK    = 8'h00;
   localparam logic [7:0] ST_MISS  = 8'h01;
   localparam logic [7:0] ST_BADOP = 8'h02;

   typedef enum logic [2:0] {
      S_IDLE,
      S_COLLECT,
      S_ISSUE,
      S_WAIT_ACK,
      S_RESP
   } state_t;

   typedef struct packed {
      logic [1:0]       op;
      logic [KEY_W-1:0] key;
      logic [VAL_W-1:0] wdata;
   } kv_req_t;

   // KV_NONE marks an opcode the store does not understand
   function automatic logic [1:0] opcode_to_kvop(input logic [7:0] opc);
      logic [1:0] op;
      case (opc)
         OP_PUT:  op = KV_PUT;
         OP_GET:  op = KV_GET;
         OP_DEL:  op = KV_DEL;
         default: op = KV_NONE;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/kv_cmd_sequencer_resp.sv
// kv_resp_serializer: sends a status byte and optionally a 64-bit value (MSB first) over tx valid/ready.
// Latency: tx_valid rises the cycle after start. Backpressure: tx_data held while tx_ready is low.
module kv_resp_serializer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  status,
   input  logic [63:0] value,
   input  logic        with_val,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done
);

   logic        vld_q, vld_d;
   logic [71:0] shr_q, shr_d;
   logic [3:0]  rem_q, rem_d;
   logic        fire;

   assign fire     = vld_q & tx_ready;
   assign done     = fire & (rem_q == 4'd0);
   assign tx_data  = shr_q[71:64];
   assign tx_valid = vld_q;

   always_comb begin
      vld_d = vld_q;
      shr_d = shr_q;
      rem_d = rem_q;
      if (start) begin
         vld_d = 1'b1;
         shr_d = {status, value};
         rem_d = with_val ? 4'd8 : 4'd0;
      end else if (fire) begin
         if (rem_q == 4'd0) begin
            vld_d = 1'b0;
         end else begin
            shr_d = {shr_q[63:0], 8'h00};
            rem_d = rem_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= 1'b0;
         shr_q <= '0;
         rem_q <= '0;
      end else begin
         vld_q <= vld_d;
         shr_q <= shr_d;
         rem_q <= rem_d;
      end
   end

endmodule

// File: rtl/kv_cmd_sequencer.sv
// Frames 13-byte UART commands, issues one KV request at a time, streams status (+GET data) back.
// Latency: last byte->kv_req 2 cycles, kv_ack->tx_valid 1 cycle. Backpressure: bytes arriving while busy
// with a command are dropped and counted; optional inter-byte timeout via KV_CMD_GAP_TIMEOUT_EN.
module kv_cmd_sequencer
    import kv_cmd_sequencer_pkg::*;
#(
    parameter int GAP_CYCLES = 100000
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              kv_req,
    output logic [1:0]        kv_op,
    output logic [KEY_W-1:0]  kv_key,
    output logic [VAL_W-1:0]  kv_wdata,
    input  logic              kv_ack,
    input  logic              kv_hit,
    input  logic [VAL_W-1:0]  kv_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    state_t            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [7:0]        opc_q, opc_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [VAL_W-1:0]  val_q, val_d;
    kv_req_t           req_q, req_d;
    logic              kv_req_q, kv_req_d;
    logic [7:0]        drop_q, drop_d;

    logic              op_ok;
    logic              pkt_last;
    logic              gap_timeout;
    logic              drop_inc;
    logic              ser_start;
    logic [7:0]        ser_status;
    logic              ser_with_val;
    logic              ser_done;

    assign op_ok    = (opcode_to_kvop(opc_q) != KV_NONE);
    assign pkt_last = rx_valid && (idx_q == 4'(PKT_BYTES - 1));

`ifdef KV_CMD_GAP_TIMEOUT_EN
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    logic [GAP_W-1:0] gap_q, gap_d;

    // A byte landing on the expiry cycle wins over the timeout
    assign gap_timeout = (state_q == S_COLLECT) && !rx_valid && (gap_q == GAP_W'(GAP_CYCLES - 1));
    assign gap_d       = ((state_q == S_COLLECT) && !rx_valid && !gap_timeout) ? gap_q + GAP_W'(1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gap_q <= '0;
        else        gap_q <= gap_d;
    end
`else
    assign gap_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (rx_valid) state_d = S_COLLECT;
            S_COLLECT:  begin
                if (pkt_last)         state_d = S_ISSUE;
                else if (gap_timeout) state_d = S_IDLE;
            end
            S_ISSUE:    state_d = op_ok ? S_WAIT_ACK : S_RESP;
            S_WAIT_ACK: if (kv_ack) state_d = S_RESP;
            S_RESP:     if (ser_done) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
    end

    always_comb begin
        idx_d        = idx_q;
        opc_d        = opc_q;
        key_d        = key_q;
        val_d        = val_q;
        req_d        = req_q;
        kv_req_d     = kv_req_q;
        ser_start    = 1'b0;
        ser_status   = ST_OK;
        ser_with_val = 1'b0;
        drop_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    opc_d = rx_data;
                    idx_d = 4'd1;
                end
            end
            S_COLLECT: begin
                if (rx_valid) begin
                    if (idx_q <= 4'd4) key_d = {key_q[KEY_W-9:0], rx_data};
                    else               val_d = {val_q[VAL_W-9:0], rx_data};
                    idx_d = pkt_last ? 4'd0 : idx_q + 4'd1;
                end else if (gap_timeout) begin
                    idx_d    = 4'd0;
                    drop_inc = 1'b1;
                end
            end
            S_ISSUE: begin
                drop_inc = rx_valid;
                if (op_ok) begin
                    kv_req_d    = 1'b1;
                    req_d.op    = opcode_to_kvop(opc_q);
                    req_d.key   = key_q;
                    req_d.wdata = (opc_q == OP_PUT) ? val_q : '0;
                end else begin
                    ser_start  = 1'b1;
                    ser_status = ST_BADOP;
                end
            end
            S_WAIT_ACK: begin
                drop_inc = rx_valid;
                if (kv_ack) begin
                    kv_req_d     = 1'b0;
                    ser_start    = 1'b1;
                    ser_status   = (req_q.op == KV_PUT || kv_hit) ? ST_OK : ST_MISS;
                    ser_with_val = (req_q.op == KV_GET) && kv_hit;
                end
            end
            S_RESP: begin
                drop_inc = rx_valid;
            end
            default: ;
        endcase
        drop_d = (drop_inc && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= '0;
            opc_q    <= '0;
            key_q    <= '0;
            val_q    <= '0;
            req_q    <= '0;
            kv_req_q <= 1'b0;
            drop_q   <= '0;
        end else begin
            idx_q    <= idx_d;
            opc_q    <= opc_d;
            key_q    <= key_d;
            val_q    <= val_d;
            req_q    <= req_d;
            kv_req_q <= kv_req_d;
            drop_q   <= drop_d;
        end
    end

    assign kv_req   = kv_req_q;
    assign kv_op    = req_q.op;
    assign kv_key   = req_q.key;
    assign kv_wdata = req_q.wdata;
    assign drop_cnt = drop_q;

    kv_resp_serializer u_resp (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (ser_start),
        .status   (ser_status),
        .value    (kv_rdata),
        .with_val (ser_with_val),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .done     (ser_done)
    );

endmodule

// File: tb/tb_kv_cmd_sequencer.sv
// Scoreboarded bench for kv_cmd_sequencer: packet stimulus feeds expected KV requests and tx bytes
// to queues; independent KV-store and tx monitors pop and compare.
module tb_kv_cmd_sequencer;

    logic        clk, rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        kv_req;
    logic [1:0]  kv_op;
    logic [31:0] kv_key;
    logic [63:0] kv_wdata;
    logic        kv_ack, kv_hit;
    logic [63:0] kv_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid, tx_ready;
    logic        busy;
    logic [7:0]  drop_cnt;

    kv_cmd_sequencer #(.GAP_CYCLES(50)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .kv_req(kv_req), .kv_op(kv_op), .kv_key(kv_key), .kv_wdata(kv_wdata),
        .kv_ack(kv_ack), .kv_hit(kv_hit), .kv_rdata(kv_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .drop_cnt(drop_cnt)
    );

    typedef struct { logic [1:0] op; logic [31:0] key; logic [63:0] wdata; bit chk_w; } exp_kv_t;
    typedef struct { bit hit; logic [63:0] rdata; int delay; } plan_t;

    exp_kv_t    exp_kv[$];
    plan_t      plan_q[$];
    logic [7:0] exp_tx[$];
    int         errors = 0;
    int         checks = 0;
    int         exp_drop = 0;
    bit         toggle_mode = 0;
    bit         tx_hold = 0;
    logic [7:0] tx_hold_dat = 0;

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: response bytes and KV op purely from the command definition
    task automatic send_pkt(input logic [7:0] opc, input logic [31:0] key, input logic [63:0] val,
                            input bit hit, input logic [63:0] rd, input int delay,
                            input int ndrop, input bit do_reset);
        logic [7:0] bytes[13];
        exp_kv_t    e;
        plan_t      p;
        bit         valid;
        int         g;
        bytes[0] = opc;
        for (int i = 0; i < 4; i++) bytes[1+i] = key[31-8*i -: 8];
        for (int i = 0; i < 8; i++) bytes[5+i] = val[63-8*i -: 8];
        valid = (opc >= 8'd1 && opc <= 8'd3);
        if (valid) begin
            e.op    = (opc == 8'd1) ? 2'b01 : (opc == 8'd2) ? 2'b10 : 2'b11;
            e.key   = key;
            e.wdata = val;
            e.chk_w = (opc == 8'd1);
            exp_kv.push_back(e);
            p.hit = hit; p.rdata = rd; p.delay = delay;
            plan_q.push_back(p);
        end
        if (!do_reset) begin
            if (!valid)              exp_tx.push_back(8'h02);
            else if (opc == 8'd1)    exp_tx.push_back(8'h00);
            else if (hit)            exp_tx.push_back(8'h00);
            else                     exp_tx.push_back(8'h01);
            if (opc == 8'd2 && hit)
                for (int i = 0; i < 8; i++) exp_tx.push_back(rd[63-8*i -: 8]);
        end
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            rx_valid = 1'b1; rx_data = bytes[i];
            g = $urandom_range(0, 2);
            if (g > 0 && i < 12) begin
                @(posedge clk); #1 rx_valid = 1'b0;
                repeat (g - 1) @(posedge clk);
            end
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        @(negedge clk); chk("kv_req_lat1", kv_req, 1'b0);
        @(negedge clk); chk("kv_req_lat2", kv_req, valid);
        for (int i = 0; i < ndrop; i++) begin
            @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'($urandom);
            if (exp_drop < 255) exp_drop++;
        end
        if (ndrop > 0) begin
            @(posedge clk); #1 rx_valid = 1'b0;
        end
        if (do_reset) begin
            repeat (2) @(negedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("rst_kv_req", kv_req, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_drop", drop_cnt, 8'd0);
            exp_drop = 0;
            @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
        end
        for (int i = 0; i < 3000 && !(busy == 1'b0 && exp_tx.size() == 0); i++) @(negedge clk);
        chk("pkt_done", (busy == 1'b0 && exp_tx.size() == 0), 1'b1);
        chk("drop_cnt", drop_cnt, exp_drop[7:0]);
    endtask

    // KV store emulation: checks each request, answers per the plan queue
    initial begin
        exp_kv_t e;
        plan_t   p;
        bit      aborted;
        kv_ack = 0; kv_hit = 0; kv_rdata = 0;
        forever begin
            @(negedge clk);
            if (kv_req === 1'b1) begin
                chk("kv_req_expected", (exp_kv.size() > 0 && plan_q.size() > 0), 1'b1);
                if (exp_kv.size() > 0) e = exp_kv.pop_front();
                else begin e.op = 0; e.key = 0; e.wdata = 0; e.chk_w = 0; end
                if (plan_q.size() > 0) p = plan_q.pop_front();
                else begin p.hit = 0; p.rdata = 0; p.delay = 0; end
                chk("kv_op", kv_op, e.op);
                chk("kv_key", kv_key, e.key);
                if (e.chk_w) chk("kv_wdata", kv_wdata, e.wdata);
                aborted = 0;
                for (int i = 0; i < p.delay; i++) begin
                    @(negedge clk);
                    if (!rst_n) aborted = 1;
                    else if (!aborted) begin
                        chk("kv_req_held", kv_req, 1'b1);
                        chk("kv_key_held", kv_key, e.key);
                    end
                end
                if (!aborted) begin
                    @(posedge clk); #1;
                    kv_ack = 1'b1; kv_hit = p.hit; kv_rdata = p.rdata;
                    @(posedge clk); #1;
                    kv_ack = 1'b0; kv_hit = 1'($urandom); kv_rdata = {$urandom, $urandom};
                    @(negedge clk);
                    chk("kv_req_release", kv_req, 1'b0);
                    chk("ack_to_tx_valid", tx_valid, 1'b1);
                end
            end
        end
    end

    // tx monitor: ordering against the scoreboard plus data stability under backpressure
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (tx_hold) begin
                chk("tx_hold_valid", tx_valid, 1'b1);
                chk("tx_hold_data", tx_data, tx_hold_dat);
            end
            tx_hold     = tx_valid && !tx_ready;
            tx_hold_dat = tx_data;
            if (tx_valid && tx_ready) begin
                chk("tx_expected", exp_tx.size() > 0, 1'b1);
                e = (exp_tx.size() > 0) ? exp_tx.pop_front() : 8'h00;
                chk("tx_byte", tx_data, e);
            end
        end
    end

    initial begin
        tx_ready = 0;
        forever begin
            @(posedge clk); #1;
            tx_ready = toggle_mode ? ~tx_ready : ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    initial begin
        logic [7:0]  opc;
        int          r;
        rst_n = 0; rx_valid = 0; rx_data = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_kv_req", kv_req, 1'b0);
        chk("reset_kv_op", kv_op, 2'b00);
        chk("reset_kv_key", kv_key, 32'h0);
        chk("reset_kv_wdata", kv_wdata, 64'h0);
        chk("reset_tx_valid", tx_valid, 1'b0);
        chk("reset_tx_data", tx_data, 8'h00);
        chk("reset_busy", busy, 1'b0);
        chk("reset_drop", drop_cnt, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1;

        send_pkt(8'h01, 32'h2A, 64'h1122334455667788, 1'b0, 64'h0, 2, 0, 0);
        toggle_mode = 1;
        send_pkt(8'h02, 32'h2A, 64'h0, 1'b1, 64'h1122334455667788, 1, 0, 0);
        toggle_mode = 0;
        send_pkt(8'h02, 32'h2B, 64'h0, 1'b0, 64'hDEADBEEF00000000, 0, 0, 0);
        send_pkt(8'h03, 32'h2A, 64'h0, 1'b0, 64'h0, 1, 0, 0);
        send_pkt(8'h03, 32'hCAFE0001, 64'h0, 1'b1, 64'h0, 3, 0, 0);
        send_pkt(8'h07, 32'h2A, 64'h0, 1'b1, 64'h0, 0, 0, 0);
        send_pkt(8'h00, 32'h1, 64'h0, 1'b1, 64'h0, 0, 0, 0);
        send_pkt(8'h01, 32'h55AA55AA, 64'h0102030405060708, 1'b1, 64'h0, 6, 3, 0);
        send_pkt(8'h02, 32'h55AA55AA, 64'h0, 1'b1, 64'h0102030405060708, 1, 0, 0);
        send_pkt(8'h02, 32'h12345678, 64'h0, 1'b1, 64'hA5A5A5A5A5A5A5A5, 10, 0, 1);
        send_pkt(8'h01, 32'h12345678, 64'hFEDCBA9876543210, 1'b1, 64'h0, 1, 0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            opc = (r < 3) ? 8'h01 : (r < 6) ? 8'h02 : (r < 9) ? 8'h03 : 8'($urandom);
            send_pkt(opc, $urandom, {$urandom, $urandom}, 1'($urandom), {$urandom, $urandom},
                     $urandom_range(0, 4), 0, 0);
        end

        send_pkt(8'h01, 32'h77, 64'h77, 1'b1, 64'h0, 263, 260, 0);
        send_pkt(8'h02, 32'h77, 64'h0, 1'b1, 64'h77, 5, 2, 0);

`ifdef KV_CMD_GAP_TIMEOUT_EN
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1 rx_valid = 1'b1; rx_data = 8'h02;
        end
        @(posedge clk); #1 rx_valid = 1'b0;
        repeat (45) @(posedge clk);
        @(negedge clk); chk("gap_still_collect", busy, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk); chk("gap_timeout_idle", busy, 1'b0);
        if (exp_drop < 255) exp_drop++;
        chk("gap_drop", drop_cnt, exp_drop[7:0]);
        send_pkt(8'h02, 32'hBEEF, 64'h0, 1'b1, 64'h0011223344556677, 1, 0, 0);
`endif

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kv_cmd_sequencer.md
Name: kv_cmd_sequencer

Overview:
- Sits between the UART byte receiver and the key-value store.
- Frames 13-byte command packets from the received byte stream and decodes opcode, key and value.
- Issues one request at a time to the KV store with a req/ack handshake.
- Streams a status byte, plus 8 value bytes for GET, to the UART transmitter with a valid/ready handshake.

Parameters:
- PKT_BYTES, 13, command packet length in bytes; fixed layout below, only 13 supported.
- KEY_W, 32, key width in bits (packet bytes 1-4).
- VAL_W, 64, value width in bits (packet bytes 5-12).
- GAP_CYCLES, 100000, inter-byte timeout in clk cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe: rx_data is valid.
- kv_req  out  1  request to the KV store; held until kv_ack.
- kv_op  out  2  01 PUT, 10 GET, 11 DEL.
- kv_key  out  KEY_W  request key.
- kv_wdata  out  VAL_W  PUT value.
- kv_ack  in  1  one-cycle completion strobe.
- kv_hit  in  1  key found; valid with kv_ack.
- kv_rdata  in  VAL_W  GET data; valid with kv_ack.
- tx_data  out  8  response byte.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  transmitter accepts the byte.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  8  saturating count of bytes dropped while not collecting.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte index 0.
- Packet layout:
  - byte0 opcode: 0x01 PUT, 0x02 GET, 0x03 DEL.
  - bytes1-4 key, MSB first.
  - bytes5-12 value, MSB first; value bytes are ignored for GET and DEL.
- States: IDLE -> COLLECT -> ISSUE -> WAIT_ACK -> RESP -> IDLE.
- IDLE: on rx_valid, latch byte0, set index to 1, go to COLLECT.
- COLLECT:
  - Each rx_valid shifts the byte into key/value at the current index and increments the index.
  - The byte at index 12 completes the packet: go to ISSUE on the next cycle.
- ISSUE:
  - Invalid opcode (anything other than 0x01-0x03): skip the KV access, set status 0x02, go to RESP.
  - Valid opcode: assert kv_req with kv_op, kv_key and kv_wdata registered, go to WAIT_ACK.
- WAIT_ACK:
  - Hold kv_req and all kv_* outputs stable.
  - On kv_ack: deassert kv_req in the same edge; latch kv_rdata; status = 0x00 if kv_hit, else 0x01 (PUT reports 0x00 regardless of kv_hit); go to RESP.
- RESP:
  - Present the status byte, then for GET with hit present kv_rdata as 8 bytes, MSB first.
  - A byte completes on a cycle with tx_valid && tx_ready.
  - tx_data is stable while tx_valid is high and tx_ready is low.
  - tx_valid deasserts the cycle after the last byte completes; return to IDLE.
  - GET miss sends the status byte only.
- Dropped bytes: rx_valid in ISSUE, WAIT_ACK or RESP drops the byte and increments drop_cnt, saturating at 255; drop_cnt clears only on reset.
- Minimum latency: last rx_valid to kv_req is 2 cycles; kv_ack to first tx_valid is 1 cycle.
- Reset mid-operation: immediate return to the reset state; kv_req and tx_valid drop asynchronously; the partial packet is discarded.

Optional Feature:
- KV_CMD_GAP_TIMEOUT_EN defined:
  - In COLLECT, a counter increments each clk and clears on rx_valid.
  - When it reaches GAP_CYCLES, discard the partial packet, return to IDLE and increment drop_cnt by 1.
  - If rx_valid arrives in the same cycle the counter reaches GAP_CYCLES, the byte is accepted and no timeout occurs.
- Undefined: no timer; COLLECT waits indefinitely.

Decomposition:
- Shared package holds:
  - opcode constants (OP_PUT/GET/DEL);
  - kv_op encodings;
  - status codes (ST_OK 0x00, ST_MISS 0x01, ST_BADOP 0x02);
  - the state enum;
  - PKT_BYTES.
- One sub-module: kv_resp_serializer, which takes a status byte and an optional 64-bit value and sends them over the tx valid/ready handshake.

Test Plan:
- PUT: bytes 01, 00 00 00 2A, 11 22 33 44 55 66 77 88 -> kv_req with op=01, key=0x2A, wdata=0x1122334455667788; kv_ack -> tx 0x00.
- GET hit: opcode 02, key 0x2A, kv_ack with kv_hit=1 and rdata=0x1122334455667788 -> tx 00 11 22 33 44 55 66 77 88, with tx_ready toggling every other cycle and data stable.
- GET miss and DEL: kv_hit=0 -> single tx byte 0x01; DEL op=11 appears on kv_op.
- Bad opcode 0x07 -> no kv_req; tx 0x02.
- Three bytes sent during WAIT_ACK -> drop_cnt=3; the next full packet is framed correctly.
- rst_n low during WAIT_ACK -> kv_req=0 immediately, busy=0; a subsequent packet processes normally.
- With the macro defined, GAP_CYCLES=50, 5 bytes then silence -> IDLE after 50 cycles, drop_cnt increments, next packet decodes correctly.
